mem_access_stage: RTL and testbench

- Memory-access stage controller of the 5-stage pipeline, between the EX/MEM latch (upstream) and the MEM/WB latch (downstream).
- Issues data-cache read/write requests for LW/SW/LL/SC and owns the LL/SC link register.
- Produces the MEM-stage result word (Output_Port_MEM) and a valid strobe for the MEM/WB latch.
- Stalls the pipeline while a cache access is outstanding.

---
 rtl/mem_access_stage_if.sv | 38 +++
 rtl/mem_access_stage.sv | 101 ++++++++++
 tb/tb_mem_access_stage.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: EX/MEM, MEM/WB, data-cache and snoop signals of the memory-access stage.
interface mem_access_stage_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   valid_MEM;
    logic                   MemRd_MEM;
    logic                   MemWr_MEM;
    logic                   LL_MEM;
    logic                   SC_MEM;
    logic [31:0]            aluout_MEM;
    logic [31:0]            busB_MEM;
    logic                   flush;
    logic                   freeze;
    logic                   dhit;
    logic [31:0]            dmemload;
    logic                   snoop_inv;
    logic [31:0]            snoop_addr;
    logic                   dmemREN;
    logic                   dmemWEN;
    logic [31:0]            dmemaddr;
    logic [31:0]            dmemstore;
    logic [31:0]            Output_Port_MEM;
    logic                   wb_valid;
    logic                   mem_stall;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        input  valid_MEM, MemRd_MEM, MemWr_MEM, LL_MEM, SC_MEM, aluout_MEM, busB_MEM,
        input  flush, freeze, dhit, dmemload, snoop_inv, snoop_addr,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, Output_Port_MEM, wb_valid, mem_stall, stall_count
    );

    modport slave (
        output valid_MEM, MemRd_MEM, MemWr_MEM, LL_MEM, SC_MEM, aluout_MEM, busB_MEM,
        output flush, freeze, dhit, dmemload, snoop_inv, snoop_addr,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, Output_Port_MEM, wb_valid, mem_stall, stall_count
    );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage controller issuing LW/SW/LL/SC cache accesses and owning the LL/SC link.
module mem_access_stage #(
    parameter int STALL_CNT_W = 16
) (
    input logic                CLK,
    input logic                nRST,
    mem_access_stage_if.master bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   rd_q, rd_d, ll_q, ll_d, sc_q, sc_d;
    logic [31:0]            addr_q, addr_d, data_q, data_d, result_q, result_d;
    logic [31:0]            lladdr_q, lladdr_d;
    logic                   llvalid_q, llvalid_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic                   op, is_sc, sc_fail, sc_reject, issue, done_hit, link_set, link_clr;
    logic                   ren, wen, wbv, stall;
    logic [31:0]            out;

    assign op        = bus.valid_MEM & ~bus.flush & (bus.MemRd_MEM | bus.MemWr_MEM);
    assign is_sc     = ~bus.MemRd_MEM & bus.SC_MEM;
    assign sc_fail   = ~llvalid_q | (lladdr_q != bus.aluout_MEM) |
                       (bus.snoop_inv & (bus.snoop_addr == bus.aluout_MEM));
    assign sc_reject = (state_q == IDLE) & op & is_sc & sc_fail;
    assign issue     = (state_q == IDLE) & op & ~sc_reject;
    assign done_hit  = (state_q == WAIT) & bus.dhit;
    assign link_set  = done_hit & ll_q;
    // every SC consumes the link; a plain store to the linked word breaks it
    assign link_clr  = ((state_q == IDLE) & op & is_sc) |
                       (done_hit & ~rd_q & ~sc_q & (addr_q == lladdr_q));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (issue ? WAIT : IDLE) :
                  (state_q == WAIT) ? (bus.dhit ? DONE : WAIT) :
                  (bus.freeze ? DONE : IDLE);
    end

    always_comb begin
        rd_d      = issue ? bus.MemRd_MEM : rd_q;
        ll_d      = issue ? bus.MemRd_MEM & bus.LL_MEM : ll_q;
        sc_d      = issue ? is_sc : sc_q;
        addr_d    = issue ? bus.aluout_MEM : addr_q;
        data_d    = issue ? bus.busB_MEM : data_q;
        result_d  = done_hit ? (rd_q ? bus.dmemload : sc_q ? 32'd1 : addr_q) : result_q;
        lladdr_d  = link_set ? addr_q : lladdr_q;
        // a snoop is judged against the link as it will stand after this edge
        llvalid_d = (link_set | (llvalid_q & ~link_clr)) &
                    ~(bus.snoop_inv & (bus.snoop_addr == lladdr_d));
        cnt_d     = (stall & ~&cnt_q) ? cnt_q + STALL_CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd_q      <= 1'b0;
            ll_q      <= 1'b0;
            sc_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            result_q  <= '0;
            lladdr_q  <= '0;
            llvalid_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            rd_q      <= rd_d;
            ll_q      <= ll_d;
            sc_q      <= sc_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            result_q  <= result_d;
            lladdr_q  <= lladdr_d;
            llvalid_q <= llvalid_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        ren   = (state_q == WAIT) & rd_q;
        wen   = (state_q == WAIT) & ~rd_q;
        wbv   = (state_q == DONE) |
                ((state_q == IDLE) & ((bus.valid_MEM & ~bus.flush & ~op) | sc_reject));
        out   = (state_q == DONE) ? result_q :
                ((state_q == IDLE) & ~op) ? bus.aluout_MEM : 32'd0;
        stall = (state_q == WAIT) | issue | bus.freeze;
    end

    // outputs are forced low for the whole time reset is held
    assign bus.dmemREN         = nRST & ren;
    assign bus.dmemWEN         = nRST & wen;
    assign bus.dmemaddr        = addr_q;
    assign bus.dmemstore       = data_q;
    assign bus.Output_Port_MEM = nRST ? out : 32'd0;
    assign bus.wb_valid        = nRST & wbv;
    assign bus.mem_stall       = nRST & stall;
    assign bus.stall_count     = cnt_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: random + directed LW/SW/LL/SC traffic against a queue scoreboard and cache model.
module tb_mem_access_stage;
    logic CLK = 1'b0;
    logic nRST = 1'b0;

    mem_access_stage_if #(.STALL_CNT_W(16)) bus();
    mem_access_stage #(.STALL_CNT_W(16)) dut (.CLK(CLK), .nRST(nRST), .bus(bus.master));

    always #5 CLK = ~CLK;

    int          pass_n = 0;
    int          total_n = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem [bit [31:0]];
    int          exp_req = 0;
    logic [31:0] exp_addr = 0;
    logic [31:0] exp_data = 0;
    int          lat_cfg = 0;
    int          frz_pct = 0;
    bit          llv = 0;
    logic [31:0] lla = 0;
    int          model_cnt = 0;
    logic [31:0] addrs[4] = '{32'h100, 32'h200, 32'h204, 32'h300};

    function automatic logic [31:0] mem_rd(input bit [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'hA5A5_0000);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total_n++;
        if (act === expv) pass_n++;
        else $display("FAIL %s: got %h expected %h", nm, act, expv);
    endtask

    // monitor: every MEM/WB capture must match the oldest expected result
    initial forever begin
        @(negedge CLK);
        if (nRST && bus.wb_valid && !bus.freeze) begin
            if (exp_q.size() == 0) begin
                total_n++;
                $display("FAIL unexpected_wb: got %h expected none", bus.Output_Port_MEM);
            end else chk("wb_data", bus.Output_Port_MEM, exp_q.pop_front());
        end
    end

    // cache model: answers after lat_cfg extra cycles and checks the request it sees
    initial begin
        int left = 0;
        bit busy = 0;
        forever begin
            @(negedge CLK);
            if (bus.dmemREN || bus.dmemWEN) begin
                if (!busy) begin
                    busy = 1;
                    left = lat_cfg;
                end
                if (left == 0) begin
                    if (exp_req == 0) begin
                        total_n++;
                        $display("FAIL spurious_req: got ren=%0d wen=%0d expected none", bus.dmemREN, bus.dmemWEN);
                    end else begin
                        chk("req_ren", 32'(bus.dmemREN), 32'(exp_req == 1));
                        chk("req_wen", 32'(bus.dmemWEN), 32'(exp_req == 2));
                        chk("req_addr", bus.dmemaddr, exp_addr);
                        if (exp_req == 2) chk("req_data", bus.dmemstore, exp_data);
                    end
                    bus.dmemload = mem_rd(exp_addr);
                    bus.dhit = 1;
                    busy = 0;
                    exp_req = 0;
                end else begin
                    left--;
                    bus.dhit = 0;
                end
            end else begin
                busy = 0;
                bus.dhit = 0;
            end
        end
    end

    // kind: 0 ALU, 1 LW, 2 SW, 3 LL, 4 SC, 5 bubble, 6 flushed op
    task automatic run(input int kind, input logic [31:0] a, input logic [31:0] d, input bit snp,
                       input logic [31:0] sa, input int nfrz, output int cyc);
        bit live, held, cap;
        logic [31:0] hv;
        bus.valid_MEM  = (kind != 5);
        bus.flush      = (kind == 6);
        bus.MemRd_MEM  = (kind == 1) || (kind == 3) || (kind == 6 && a[2]);
        bus.MemWr_MEM  = (kind == 2) || (kind == 4) || (kind == 6 && !a[2]);
        bus.LL_MEM     = (kind == 3);
        bus.SC_MEM     = (kind == 4);
        bus.aluout_MEM = a;
        bus.busB_MEM   = d;
        bus.snoop_inv  = snp;
        bus.snoop_addr = sa;
        bus.freeze     = (nfrz > 0) || ($urandom_range(0, 99) < frz_pct);
        live = (kind < 5);
        if (snp && llv && sa == lla) llv = 0;
        case (kind)
            0: exp_q.push_back(a);
            1, 3: begin
                exp_req = 1; exp_addr = a;
                exp_q.push_back(mem_rd(a));
                if (kind == 3) begin llv = 1; lla = a; end
            end
            2: begin
                exp_req = 2; exp_addr = a; exp_data = d; mem[a] = d;
                if (lla == a) llv = 0;
                exp_q.push_back(a);
            end
            4: begin
                if (llv && lla == a && !(snp && sa == a)) begin
                    exp_req = 2; exp_addr = a; exp_data = d; mem[a] = d;
                    exp_q.push_back(32'd1);
                end else exp_q.push_back(32'd0);
                llv = 0;
            end
            default: ;
        endcase
        cyc = 0;
        held = 0;
        hv = 0;
        forever begin
            @(negedge CLK);
            cap = bus.wb_valid && !bus.freeze;
            if (held) begin
                chk("hold_valid", 32'(bus.wb_valid), 32'd1);
                chk("hold_data", bus.Output_Port_MEM, hv);
                chk("hold_noreq", 32'(bus.dmemREN | bus.dmemWEN), 32'd0);
            end
            held = bus.wb_valid && bus.freeze;
            hv = bus.Output_Port_MEM;
            if (!live) begin
                chk("bubble_wb", 32'(bus.wb_valid), 32'd0);
                chk("bubble_stall", 32'(bus.mem_stall), 32'(bus.freeze));
                chk("stall_count", 32'(bus.stall_count), 32'(model_cnt));
                model_cnt += int'(bus.freeze);
                break;
            end
            chk("stall", 32'(bus.mem_stall), 32'(!cap));
            if (cap) begin
                chk("stall_count", 32'(bus.stall_count), 32'(model_cnt));
                break;
            end
            model_cnt++;
            cyc++;
            if (cyc > 40) begin
                total_n++;
                $display("FAIL timeout: got no capture in %0d cycles expected capture", cyc);
                break;
            end
            @(posedge CLK); #1;
            bus.snoop_inv = 0;
            bus.freeze = (cyc < nfrz) || ($urandom_range(0, 99) < frz_pct);
        end
        @(posedge CLK); #1;
        bus.valid_MEM = 0;
        bus.flush = 0;
        bus.snoop_inv = 0;
        bus.MemRd_MEM = 0;
        bus.MemWr_MEM = 0;
        bus.LL_MEM = 0;
        bus.SC_MEM = 0;
        bus.freeze = 0;
    endtask

    initial begin
        int c;
        {bus.valid_MEM, bus.MemRd_MEM, bus.MemWr_MEM, bus.LL_MEM, bus.SC_MEM} = '0;
        {bus.flush, bus.freeze, bus.dhit, bus.snoop_inv} = '0;
        bus.aluout_MEM = 32'h1234;
        bus.busB_MEM = 0;
        bus.dmemload = 0;
        bus.snoop_addr = 0;
        #1;
        chk("rst_ren", 32'(bus.dmemREN), 32'd0);
        chk("rst_wen", 32'(bus.dmemWEN), 32'd0);
        chk("rst_wb", 32'(bus.wb_valid), 32'd0);
        chk("rst_out", bus.Output_Port_MEM, 32'd0);
        chk("rst_stall", 32'(bus.mem_stall), 32'd0);
        chk("rst_cnt", 32'(bus.stall_count), 32'd0);
        @(posedge CLK); #1;
        nRST = 1;

        mem[32'h100] = 32'hDEADBEEF;
        lat_cfg = 2;
        run(1, 32'h100, 0, 0, 0, 0, c);
        chk("lw_latency", 32'(c), 32'd4);
        chk("lw_stall_count", 32'(bus.stall_count), 32'd4);
        lat_cfg = 0;
        run(0, 32'h55, 0, 0, 0, 0, c);
        chk("alu_latency", 32'(c), 32'd0);

        run(3, 32'h200, 0, 0, 0, 0, c);
        run(4, 32'h200, 32'h7, 0, 0, 0, c);
        run(4, 32'h200, 32'h8, 0, 0, 0, c);
        run(3, 32'h200, 0, 0, 0, 0, c);
        run(5, 0, 0, 1, 32'h200, 0, c);
        run(4, 32'h200, 32'h9, 0, 0, 0, c);
        run(3, 32'h200, 0, 0, 0, 0, c);
        run(5, 0, 0, 1, 32'h204, 0, c);
        run(4, 32'h200, 32'hA, 0, 0, 0, c);

        run(1, 32'h204, 0, 0, 0, 5, c);
        chk("freeze_latency", 32'(c), 32'd5);
        run(5, 0, 0, 0, 0, 0, c);

        run(3, 32'h300, 0, 0, 0, 0, c);
        lat_cfg = 3;
        bus.valid_MEM = 1; bus.MemRd_MEM = 1; bus.aluout_MEM = 32'h100; bus.freeze = 0;
        exp_req = 1; exp_addr = 32'h100;
        @(negedge CLK);
        @(negedge CLK);
        chk("wait_ren", 32'(bus.dmemREN), 32'd1);
        #2 nRST = 0;
        #1;
        chk("arst_ren", 32'(bus.dmemREN), 32'd0);
        chk("arst_wen", 32'(bus.dmemWEN), 32'd0);
        chk("arst_wb", 32'(bus.wb_valid), 32'd0);
        chk("arst_stall", 32'(bus.mem_stall), 32'd0);
        chk("arst_cnt", 32'(bus.stall_count), 32'd0);
        bus.valid_MEM = 0; bus.MemRd_MEM = 0;
        exp_req = 0;
        @(posedge CLK); #1;
        nRST = 1;
        llv = 0;
        model_cnt = 0;
        lat_cfg = 1;
        run(4, 32'h300, 32'h9, 0, 0, 0, c);
        run(2, 32'h104, 32'h1234, 0, 0, 0, c);
        run(1, 32'h104, 0, 0, 0, 0, c);

        frz_pct = 30;
        for (int i = 0; i < 300; i++) begin
            lat_cfg = $urandom_range(0, 3);
            run($urandom_range(0, 6), addrs[$urandom_range(0, 3)], $urandom,
                $urandom_range(0, 4) == 0, addrs[$urandom_range(0, 3)], 0, c);
        end
        frz_pct = 0;
        repeat (3) @(negedge CLK);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
